// File: rtl/pipe_add_sub_if.sv
// rtl/pipe_add_sub_if.sv - operand/result handshake bundle for the pipelined add/sub unit
interface pipe_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipe_add_sub.sv
// rtl/pipe_add_sub.sv - segmented carry-chain adder/subtractor, one segment per pipeline stage
module pipe_add_sub #(
  parameter int WIDTH          = 8,
  parameter int STAGES         = 2,
  parameter int USE_FULL_ADDER = 1,
  parameter int SATURATE       = 0
) (
  input  logic         clk,
  input  logic         rst,
  pipe_add_sub_if.slave bus
);
  localparam int SEG = WIDTH / STAGES;

  // Stage k registers: valid, sub flag, carry out of segment k, overflow
  // (meaningful only in the last stage), raw operands still to be consumed,
  // and result slices completed so far.
  logic             v_q  [STAGES];
  logic             s_q  [STAGES];
  logic             c_q  [STAGES];
  logic             o_q  [STAGES];
  logic [WIDTH-1:0] a_q  [STAGES];
  logic [WIDTH-1:0] b_q  [STAGES];
  logic [WIDTH-1:0] r_q  [STAGES];

  logic             nx_v [STAGES];
  logic             nx_s [STAGES];
  logic             nx_c [STAGES];
  logic             nx_o [STAGES];
  logic [WIDTH-1:0] nx_a [STAGES];
  logic [WIDTH-1:0] nx_b [STAGES];
  logic [WIDTH-1:0] nx_r [STAGES];

  logic advance;

  // The whole pipe moves as one; a full, unconsumed output freezes every stage.
  assign advance      = !v_q[STAGES-1] || bus.out_ready;
  assign bus.in_ready = advance;

  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = r_q[STAGES-1];
  assign bus.cout      = c_q[STAGES-1];
  assign bus.ovf       = o_q[STAGES-1];

  function automatic logic [WIDTH-1:0] sat_val(input logic neg);
    sat_val = neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             src_v;
    logic             src_s;
    logic             src_c;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] src_r;
    logic [SEG-1:0]   b_seg;
    logic [SEG:0]     seg;
    logic [WIDTH-1:0] res;
    logic             raw_ovf;

    if (k == 0) begin : g_src
      // Stage 0 takes operands straight from the port; subtract forces the +1
      // and ignores cin, add honours cin only when configured as a full adder.
      assign src_v = bus.in_valid;
      assign src_s = bus.sub;
      assign src_a = bus.a;
      assign src_b = bus.b;
      assign src_r = '0;
      assign src_c = bus.sub | ((USE_FULL_ADDER != 0) & bus.cin);
    end else begin : g_src
      assign src_v = v_q[k-1];
      assign src_s = s_q[k-1];
      assign src_a = a_q[k-1];
      assign src_b = b_q[k-1];
      assign src_r = r_q[k-1];
      assign src_c = c_q[k-1];
    end

    assign b_seg = src_s ? ~src_b[k*SEG +: SEG] : src_b[k*SEG +: SEG];
    assign seg   = {1'b0, src_a[k*SEG +: SEG]} + {1'b0, b_seg} + {{SEG{1'b0}}, src_c};

    // Drop this segment's sum into the partially built result word.
    always_comb begin
      res                = src_r;
      res[k*SEG +: SEG]  = seg[SEG-1:0];
    end

    if (k == STAGES - 1) begin : g_last
      logic b_msb;
      assign b_msb   = src_s ^ src_b[WIDTH-1];
      assign raw_ovf = (src_a[WIDTH-1] == b_msb) && (res[WIDTH-1] != src_a[WIDTH-1]);
      assign nx_r[k] = ((SATURATE != 0) && raw_ovf) ? sat_val(src_a[WIDTH-1]) : res;
    end else begin : g_mid
      assign raw_ovf = 1'b0;
      assign nx_r[k] = res;
    end

    assign nx_v[k] = src_v;
    assign nx_s[k] = src_s;
    assign nx_c[k] = seg[SEG];
    assign nx_o[k] = raw_ovf;
    assign nx_a[k] = src_a;
    assign nx_b[k] = src_b;
  end

  // Shift every stage together on advance, hold all of them otherwise.
  always_ff @(posedge clk) begin
    for (int k = 0; k < STAGES; k++) begin
      if (rst) begin
        v_q[k] <= 1'b0;
        s_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end else if (advance) begin
        v_q[k] <= nx_v[k];
        s_q[k] <= nx_s[k];
        c_q[k] <= nx_c[k];
        o_q[k] <= nx_o[k];
        a_q[k] <= nx_a[k];
        b_q[k] <= nx_b[k];
        r_q[k] <= nx_r[k];
      end
    end
  end
endmodule

// File: tb/tb_pipe_add_sub.sv
// tb/tb_pipe_add_sub.sv - randomized and directed checks of pipe_add_sub in three configurations
module tb_pipe_add_sub;
  logic       clk       = 1'b0;
  logic       rst       = 1'b1;
  logic       in_valid  = 1'b1;
  logic       out_ready = 1'b0;
  logic       cin       = 1'b0;
  logic       sub       = 1'b0;
  logic [7:0] a         = 8'h5A;
  logic [7:0] b         = 8'hA5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  // instance 0: default, 1: saturating, 2: single stage without carry-in
  pipe_add_sub_if #(.WIDTH(8)) if_def ();
  pipe_add_sub_if #(.WIDTH(8)) if_sat ();
  pipe_add_sub_if #(.WIDTH(8)) if_one ();

  assign if_def.in_valid = in_valid;  assign if_def.a = a;  assign if_def.b = b;
  assign if_def.cin = cin;  assign if_def.sub = sub;  assign if_def.out_ready = out_ready;
  assign if_sat.in_valid = in_valid;  assign if_sat.a = a;  assign if_sat.b = b;
  assign if_sat.cin = cin;  assign if_sat.sub = sub;  assign if_sat.out_ready = out_ready;
  assign if_one.in_valid = in_valid;  assign if_one.a = a;  assign if_one.b = b;
  assign if_one.cin = cin;  assign if_one.sub = sub;  assign if_one.out_ready = out_ready;

  pipe_add_sub #(.WIDTH(8), .STAGES(2), .USE_FULL_ADDER(1), .SATURATE(0)) u_def (
    .clk(clk), .rst(rst), .bus(if_def));
  pipe_add_sub #(.WIDTH(8), .STAGES(2), .USE_FULL_ADDER(1), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .bus(if_sat));
  pipe_add_sub #(.WIDTH(8), .STAGES(1), .USE_FULL_ADDER(0), .SATURATE(0)) u_one (
    .clk(clk), .rst(rst), .bus(if_one));

  logic [2:0] ov, ir, co, of;
  logic [7:0] sm [3];
  assign ov = {if_one.out_valid, if_sat.out_valid, if_def.out_valid};
  assign ir = {if_one.in_ready,  if_sat.in_ready,  if_def.in_ready};
  assign co = {if_one.cout,      if_sat.cout,      if_def.cout};
  assign of = {if_one.ovf,       if_sat.ovf,       if_def.ovf};
  assign sm[0] = if_def.sum;
  assign sm[1] = if_sat.sum;
  assign sm[2] = if_one.sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit cfg_ufa(input int i);
    return i != 2;
  endfunction

  function automatic bit cfg_sat(input int i);
    return i == 1;
  endfunction

  // Plain integer arithmetic: returns {sum, cout, ovf}.
  function automatic logic [9:0] ref_calc(input logic [7:0] ra, rb, input logic rc, rs,
                                          input bit ufa, sat);
    int total, sa, sb, sres, ci;
    logic [7:0] s;
    logic c, o;
    sa = $signed(ra);
    sb = $signed(rb);
    ci = (!rs && ufa && rc) ? 1 : 0;
    if (rs) begin
      total = int'(ra) + (255 - int'(rb)) + 1;
      sres  = sa - sb;
    end else begin
      total = int'(ra) + int'(rb) + ci;
      sres  = sa + sb + ci;
    end
    s = total[7:0];
    c = total[8];
    o = (sres > 127) || (sres < -128);
    if (sat && o) s = (sres > 127) ? 8'h7F : 8'h80;
    return {s, c, o};
  endfunction

  logic [9:0] exp_q [3][64];
  int         wp    [3] = '{0, 0, 0};
  int         rp    [3] = '{0, 0, 0};
  int         pops  [3] = '{0, 0, 0};
  logic       hold_v[3] = '{1'b0, 1'b0, 1'b0};
  logic [9:0] hold_d[3];
  logic [9:0] cap   [3];

  // Scoreboard per instance: push on capture, pop and compare on consume,
  // and require a stalled result to stay put.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        wp[i]     <= 0;
        rp[i]     <= 0;
        hold_v[i] <= 1'b0;
      end else begin
        if (hold_v[i]) begin
          check($sformatf("hold_valid%0d", i), ov[i], 1'b1);
          check($sformatf("hold_data%0d", i), {sm[i], co[i], of[i]}, hold_d[i]);
        end
        if (ov[i] && out_ready) begin
          if (rp[i] == wp[i]) begin
            check($sformatf("unexpected%0d", i), 1'b1, 1'b0);
          end else begin
            check($sformatf("result%0d", i), {sm[i], co[i], of[i]}, exp_q[i][rp[i] % 64]);
            rp[i]   <= rp[i] + 1;
            pops[i] <= pops[i] + 1;
          end
        end
        hold_v[i] <= ov[i] && !out_ready;
        hold_d[i] <= {sm[i], co[i], of[i]};
        if (in_valid && ir[i]) begin
          exp_q[i][wp[i] % 64] <= ref_calc(a, b, cin, sub, cfg_ufa(i), cfg_sat(i));
          wp[i]                <= wp[i] + 1;
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // One operation into an empty pipe; checks exact latency of each instance.
  task automatic directed_op(input logic [7:0] oa, ob, input logic oc, os);
    @(posedge clk); #1;
    in_valid = 1'b1; a = oa; b = ob; cin = oc; sub = os; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("lat_one", ov[2], 1'b1);
    check("early_def", ov[0], 1'b0);
    check("early_sat", ov[1], 1'b0);
    cap[2] = {sm[2], co[2], of[2]};
    @(negedge clk);
    check("lat_def", ov[0], 1'b1);
    check("lat_sat", ov[1], 1'b1);
    cap[0] = {sm[0], co[0], of[0]};
    cap[1] = {sm[1], co[1], of[1]};
  endtask

  logic [7:0] bp_a [4];
  logic [7:0] bp_b [4];
  logic       bp_c [4];
  logic       bp_s [4];
  logic [9:0] first_exp;
  logic [7:0] first_sum;
  int         idx;
  int         pops_before;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", ov, 3'b000);
    check("rst_sum", sm[0], 8'h00);
    check("rst_flags", {co, of}, 6'b0);
    check("rst_ready", ir, 3'b111);
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_discard", ov, 3'b000);
    end

    idle(1);
    directed_op(8'hFF, 8'h01, 1'b1, 1'b0);
    check("cross_sum", cap[0][9:2], 8'h01);
    check("cross_cout", cap[0][1], 1'b1);
    check("cross_ovf", cap[0][0], 1'b0);

    idle(2);
    directed_op(8'h05, 8'h07, 1'b1, 1'b1);
    check("sub_sum", cap[0][9:2], 8'hFE);
    check("sub_cout", cap[0][1], 1'b0);
    check("sub_ovf", cap[0][0], 1'b0);

    idle(2);
    directed_op(8'h70, 8'h20, 1'b0, 1'b0);
    check("sat_pos_sum", cap[1][9:2], 8'h7F);
    check("sat_pos_ovf", cap[1][0], 1'b1);
    check("wrap_pos_sum", cap[0][9:2], 8'h90);

    idle(2);
    directed_op(8'h80, 8'h01, 1'b0, 1'b1);
    check("sat_neg_sum", cap[1][9:2], 8'h80);
    check("sat_neg_ovf", cap[1][0], 1'b1);
    check("sat_neg_cout", cap[1][1], 1'b1);

    idle(2);
    directed_op(8'h0F, 8'h01, 1'b1, 1'b0);
    check("one_sum", cap[2][9:2], 8'h10);
    check("one_cout", cap[2][1], 1'b0);

    // backpressure: four back-to-back sets, three stalled cycles after first result
    idle(3);
    for (int i = 0; i < 4; i++) begin
      bp_a[i] = 8'($urandom);
      bp_b[i] = 8'($urandom);
      bp_c[i] = 1'($urandom);
      bp_s[i] = 1'($urandom);
    end
    first_exp   = ref_calc(bp_a[0], bp_b[0], bp_c[0], bp_s[0], 1'b1, 1'b0);
    pops_before = pops[0];
    idx         = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk); #1;
      out_ready = !(t >= 2 && t <= 4);
      in_valid  = (idx < 4);
      if (idx < 4) begin
        a = bp_a[idx]; b = bp_b[idx]; cin = bp_c[idx]; sub = bp_s[idx];
      end
      @(negedge clk);
      if (t >= 2 && t <= 4) begin
        check("stall_ready", ir[0], 1'b0);
        check("stall_valid", ov[0], 1'b1);
        if (t == 2) begin
          first_sum = sm[0];
          check("stall_first", {sm[0], co[0], of[0]}, first_exp);
        end else begin
          check("stall_hold", sm[0], first_sum);
        end
      end
      if (in_valid && ir[0]) idx++;
    end
    idle(2);
    @(negedge clk);
    check("bp_count", pops[0] - pops_before, 4);

    // reset with two operations in flight
    idle(2);
    @(posedge clk); #1;
    in_valid = 1'b1; a = 8'h11; b = 8'h22; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    a = 8'h33; b = 8'h44;
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", ov, 3'b000);
    check("mid_rst_sum", sm[0], 8'h00);
    check("mid_rst_flags", {co, of}, 6'b0);
    repeat (3) begin
      @(negedge clk);
      check("no_stale", ov, 3'b000);
    end
    directed_op(8'h3C, 8'h44, 1'b0, 1'b0);
    check("post_rst_sum", cap[0][9:2], 8'h80);
    check("post_rst_ovf", cap[0][0], 1'b1);
    check("post_rst_sat", cap[1][9:2], 8'h7F);

    // randomized traffic with random backpressure
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 8'($urandom);
      b         = 8'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    idle(6);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain%0d", i), wp[i] - rp[i], 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
